// File: rtl/vscale_csr_host_port_pkg.sv
// Shared CSR constants: address map, host-port op and state encodings, read-only field test.
package vscale_csr_host_port_pkg;

    localparam logic [11:0] CSR_ADDR_MSTATUS  = 12'h300;
    localparam logic [11:0] CSR_ADDR_MIE      = 12'h304;
    localparam logic [11:0] CSR_ADDR_MSCRATCH = 12'h340;
    localparam logic [11:0] CSR_ADDR_MCPUID   = 12'hF00;
    localparam logic [11:0] CSR_ADDR_MIMPID   = 12'hF01;

    // Top two address bits equal to this value mark a read-only CSR.
    localparam logic [1:0] CSR_RO_FIELD = 2'b11;

    typedef enum logic [1:0] {
        HOST_OP_READ  = 2'b00,
        HOST_OP_WRITE = 2'b01,
        HOST_OP_SET   = 2'b10,
        HOST_OP_CLEAR = 2'b11
    } host_op_e;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_RD   = 2'b01,
        ST_WR   = 2'b10,
        ST_RESP = 2'b11
    } host_state_e;

    function automatic logic csr_addr_read_only(input logic [1:0] top_bits);
        return top_bits == CSR_RO_FIELD;
    endfunction

endpackage

// File: rtl/vscale_csr_host_port_if.sv
// Host request/response handshake bundle for the CSR host port.
interface vscale_csr_host_port_if #(
    parameter int ADDR_W = 12,
    parameter int DATA_W = 32
);
    logic              req_valid;
    logic              req_ready;
    logic [1:0]        req_op;
    logic [ADDR_W-1:0] req_addr;
    logic [DATA_W-1:0] req_wdata;
    logic              resp_valid;
    logic              resp_ready;
    logic [DATA_W-1:0] resp_rdata;
    logic              resp_err;

    modport master (
        output req_valid, req_op, req_addr, req_wdata, resp_ready,
        input  req_ready, resp_valid, resp_rdata, resp_err
    );

    modport slave (
        input  req_valid, req_op, req_addr, req_wdata, resp_ready,
        output req_ready, resp_valid, resp_rdata, resp_err
    );
endinterface

// File: rtl/vscale_csr_host_port.sv
// Debug-host access to the CSR file: read, write, set or clear one CSR per request.
// Define CSR_HOST_RMW_EN to enable SET/CLEAR; otherwise they return an error without writing.
module vscale_csr_host_port
    import vscale_csr_host_port_pkg::*;
#(
    parameter int ADDR_W = 12,
    parameter int DATA_W = 32
) (
    input  logic                clk,
    input  logic                reset,
    vscale_csr_host_port_if.slave host,
    input  logic                core_csr_busy,
    output logic                host_active,
    output logic [ADDR_W-1:0]   csr_addr,
    output logic                csr_en,
    output logic                csr_wen,
    output logic [DATA_W-1:0]   csr_wdata,
    input  logic [DATA_W-1:0]   csr_rdata,
    input  logic                csr_defined
);

    host_state_e       r_state;
    host_op_e          r_op;
    logic [ADDR_W-1:0] r_addr;
    logic [DATA_W-1:0] r_wdata;
    logic [DATA_W-1:0] r_resp_rdata;
    logic [DATA_W-1:0] r_csr_wdata;
    logic              r_resp_valid;
    logic              r_resp_err;
    logic              r_csr_en;
    logic              r_csr_wen;

    logic              w_req_ready;
    logic              w_accept;
    logic              w_is_rmw;
    logic              w_rmw_blocked;
    logic              w_read_only;
    logic              w_rd_err;
    logic              w_rd_no_write;
    logic [DATA_W-1:0] w_wr_data;

    assign w_req_ready = (r_state == ST_IDLE) && !core_csr_busy;
    assign w_accept    = host.req_valid && w_req_ready;
    assign w_is_rmw    = (r_op == HOST_OP_SET) || (r_op == HOST_OP_CLEAR);

`ifdef CSR_HOST_RMW_EN
    assign w_rmw_blocked = 1'b0;
`else
    assign w_rmw_blocked = w_is_rmw;
`endif

    assign w_read_only   = csr_addr_read_only(r_addr[ADDR_W-1 -: 2]);
    // An undefined CSR faults for every op; read-only and disabled RMW fault only modifying ops.
    assign w_rd_err      = !csr_defined ||
                           ((r_op != HOST_OP_READ) && (w_read_only || w_rmw_blocked));
    assign w_rd_no_write = (r_op == HOST_OP_READ) || (w_is_rmw && (r_wdata == '0));

    always_comb begin
        w_wr_data = r_wdata;
        case (r_op)
            HOST_OP_SET:   w_wr_data = csr_rdata | r_wdata;
            HOST_OP_CLEAR: w_wr_data = csr_rdata & ~r_wdata;
            default:       w_wr_data = r_wdata;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state      <= ST_IDLE;
            r_op         <= HOST_OP_READ;
            r_addr       <= '0;
            r_wdata      <= '0;
            r_resp_rdata <= '0;
            r_csr_wdata  <= '0;
            r_resp_valid <= 1'b0;
            r_resp_err   <= 1'b0;
            r_csr_en     <= 1'b0;
            r_csr_wen    <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_accept) begin
                        r_op       <= host_op_e'(host.req_op);
                        r_addr     <= host.req_addr;
                        r_wdata    <= host.req_wdata;
                        r_resp_err <= 1'b0;
                        r_csr_en   <= 1'b1;
                        r_state    <= ST_RD;
                    end
                end
                ST_RD: begin
                    r_resp_rdata <= csr_rdata;
                    r_resp_err   <= w_rd_err;
                    if (w_rd_err || w_rd_no_write) begin
                        r_csr_en     <= 1'b0;
                        r_resp_valid <= 1'b1;
                        r_state      <= ST_RESP;
                    end else begin
                        r_csr_wen   <= 1'b1;
                        r_csr_wdata <= w_wr_data;
                        r_state     <= ST_WR;
                    end
                end
                ST_WR: begin
                    r_csr_en     <= 1'b0;
                    r_csr_wen    <= 1'b0;
                    r_csr_wdata  <= '0;
                    r_resp_valid <= 1'b1;
                    r_state      <= ST_RESP;
                end
                ST_RESP: begin
                    if (host.resp_ready) begin
                        r_resp_valid <= 1'b0;
                        r_state      <= ST_IDLE;
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    assign host.req_ready  = w_req_ready;
    assign host.resp_valid = r_resp_valid;
    assign host.resp_rdata = r_resp_rdata;
    assign host.resp_err   = r_resp_err;
    assign host_active     = (r_state != ST_IDLE);
    assign csr_addr        = r_addr;
    assign csr_en          = r_csr_en;
    assign csr_wen         = r_csr_wen;
    assign csr_wdata       = r_csr_wdata;

endmodule
